// File: rtl/oam_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : oam_write_buffer
// Description : Queues CPU OAM byte writes and replays them into sprite OAM
//               only during PPU vblank, after a settle delay. Optional
//               tail-write coalescing is enabled with OAM_COALESCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_write_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SETTLE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_oam_we,
    input  logic [ADDR_W-1:0]       cpu_oam_addr,
    input  logic [DATA_W-1:0]       cpu_oam_data,
    output logic                    cpu_stall,
    input  logic                    ppu_vblank,
    output logic                    oam_we,
    output logic [ADDR_W-1:0]       oam_addr,
    output logic [DATA_W-1:0]       oam_data,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    drain_done
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [3:0]         c_SETTLE  = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
    logic [DATA_W-1:0]  r_mem_data [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_settle_cnt;
    logic [3:0]         w_settle_nxt;
    logic               r_vb_q;

    logic               r_oam_we;
    logic [ADDR_W-1:0]  r_oam_addr;
    logic [DATA_W-1:0]  r_oam_data;
    logic               r_drain_done;

    logic               w_full;
    logic               w_empty;
    logic               w_rise;
    logic               w_push;
    logic               w_pop;
    logic               w_coal;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_rise  = ppu_vblank && !r_vb_q;

    // Popping is gated by vblank so a falling edge stops the drain in the same cycle.
    assign w_pop   = (r_state == ST_DRAIN) && !w_empty && ppu_vblank;

`ifdef OAM_COALESCE_EN
    logic [c_PTR_W-1:0] w_tail_ptr;
    assign w_tail_ptr = r_wr_ptr - c_PTR_ONE;
    assign w_coal     = cpu_oam_we && !w_empty
                        && (r_mem_addr[w_tail_ptr] == cpu_oam_addr)
                        && !(w_pop && (r_rd_ptr == w_tail_ptr));
`else
    assign w_coal     = 1'b0;
`endif

    assign w_push    = cpu_oam_we && !w_full && !w_coal;
    assign cpu_stall = cpu_oam_we && w_full && !w_coal;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        case (r_state)
            ST_WAIT: begin
                if (w_rise) begin
                    if (c_SETTLE == 4'd0) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = c_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!ppu_vblank) begin
                    w_state_nxt  = ST_WAIT;
                    w_settle_nxt = 4'd0;
                end else if (r_settle_cnt <= 4'd1) begin
                    w_state_nxt  = ST_DRAIN;
                    w_settle_nxt = 4'd0;
                end else begin
                    w_settle_nxt = r_settle_cnt - 4'd1;
                end
            end
            ST_DRAIN: begin
                if (!ppu_vblank) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt  = ST_WAIT;
                w_settle_nxt = 4'd0;
            end
        endcase
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= cpu_oam_addr;
            r_mem_data[r_wr_ptr] <= cpu_oam_data;
        end
`ifdef OAM_COALESCE_EN
        if (w_coal) begin
            r_mem_data[w_tail_ptr] <= cpu_oam_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= ST_WAIT;
            r_settle_cnt <= 4'd0;
            r_vb_q       <= 1'b0;
            r_oam_we     <= 1'b0;
            r_oam_addr   <= '0;
            r_oam_data   <= '0;
            r_drain_done <= 1'b0;
        end else begin
            r_vb_q       <= ppu_vblank;
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_count      <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_oam_addr <= r_mem_addr[r_rd_ptr];
                r_oam_data <= r_mem_data[r_rd_ptr];
            end
            r_oam_we     <= w_pop;
            r_drain_done <= w_pop && (w_count_nxt == '0);
        end
    end

    assign oam_we     = r_oam_we;
    assign oam_addr   = r_oam_addr;
    assign oam_data   = r_oam_data;
    assign pending    = r_count;
    assign drain_done = r_drain_done;

endmodule
`default_nettype wire

// File: tb/tb_oam_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_write_buffer
// Description : Self-checking bench for oam_write_buffer (table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_write_buffer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int SETTLE = 4;
`ifdef OAM_COALESCE_EN
    localparam bit c_COAL = 1'b1;
`else
    localparam bit c_COAL = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cpu_oam_we = 1'b0;
    logic [ADDR_W-1:0]      cpu_oam_addr = '0;
    logic [DATA_W-1:0]      cpu_oam_data = '0;
    logic                   cpu_stall;
    logic                   ppu_vblank = 1'b0;
    logic                   oam_we;
    logic [ADDR_W-1:0]      oam_addr;
    logic [DATA_W-1:0]      oam_data;
    logic [$clog2(DEPTH):0] pending;
    logic                   drain_done;

    oam_write_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SETTLE (SETTLE)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_oam_we   (cpu_oam_we),
        .cpu_oam_addr (cpu_oam_addr),
        .cpu_oam_data (cpu_oam_data),
        .cpu_stall    (cpu_stall),
        .ppu_vblank   (ppu_vblank),
        .oam_we       (oam_we),
        .oam_addr     (oam_addr),
        .oam_data     (oam_data),
        .pending      (pending),
        .drain_done   (drain_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       stall;
        logic [3:0] pend;
    } vec_t;

    wr_t  sb[$];
    wr_t  mon_e;
    vec_t vecs[9];

    int n_checks = 0;
    int n_fail   = 0;
    int n_we     = 0;
    int n_done   = 0;
    int base_we;
    int base_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every OAM write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (!rst && oam_we === 1'b1) begin
            n_we++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write", oam_addr, oam_data);
            end else begin
                mon_e = sb.pop_front();
                check("oam_addr", 32'(oam_addr), 32'(mon_e.addr));
                check("oam_data", 32'(oam_data), 32'(mon_e.data));
            end
        end
        if (!rst && drain_done === 1'b1) n_done++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input bit coal);
        int  guard;
        wr_t t;
        @(negedge clk);
        cpu_oam_we   = 1'b1;
        cpu_oam_addr = a;
        cpu_oam_data = d;
        #1;
        guard = 0;
        while (cpu_stall && guard < 500) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("write_accept_timeout", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        if (coal && sb.size() > 0) begin
            t = sb.pop_back();
            t.data = d;
        end else begin
            t.addr = a;
            t.data = d;
        end
        sb.push_back(t);
        cpu_oam_we = 1'b0;
    endtask

    task automatic wait_we(input int target, input int max_cyc);
        int g;
        g = 0;
        while (n_we < target && g < max_cyc) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("wait_we_timeout", 32'(n_we >= target), 32'd1);
    endtask

    task automatic wait_empty(input int max_cyc);
        int g;
        g = 0;
        while ((pending != '0 || sb.size() != 0) && g < max_cyc) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("drain_timeout", 32'(pending), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wr_t t;
        for (int i = 0; i < 9; i++) begin
            vecs[i].addr  = 8'(8'h50 + i);
            vecs[i].data  = 8'(8'hA0 + i);
            vecs[i].stall = (i == 8);
            vecs[i].pend  = (i < 8) ? 4'(i + 1) : 4'd8;
        end

        // Reset state
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_oam_we",     32'(oam_we),     32'd0);
        check("rst_oam_addr",   32'(oam_addr),   32'd0);
        check("rst_oam_data",   32'(oam_data),   32'd0);
        check("rst_pending",    32'(pending),    32'd0);
        check("rst_drain_done", 32'(drain_done), 32'd0);
        check("rst_cpu_stall",  32'(cpu_stall),  32'd0);

        // Basic queue-then-drain with settle latency
        base_we = n_we; base_done = n_done;
        cpu_write(8'h00, 8'h11, 1'b0);
        cpu_write(8'h01, 8'h22, 1'b0);
        cpu_write(8'h02, 8'h33, 1'b0);
        tick(1);
        check("t1_pending", 32'(pending), 32'd3);
        check("t1_no_write_outside_vblank", 32'(n_we - base_we), 32'd0);
        ppu_vblank = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t1_oam_we_timing",     32'(oam_we),     32'(k >= 6));
            check("t1_drain_done_timing", 32'(drain_done), 32'(k == 8));
        end
        tick(3);
        #1;
        check("t1_write_count", 32'(n_we - base_we),     32'd3);
        check("t1_done_count",  32'(n_done - base_done), 32'd1);
        check("t1_pending_end", 32'(pending),            32'd0);
        @(negedge clk);
        ppu_vblank = 1'b0;
        tick(2);

        // Table-driven fill to full, ninth write stalls
        base_we = n_we; base_done = n_done;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cpu_oam_we   = 1'b1;
            cpu_oam_addr = vecs[i].addr;
            cpu_oam_data = vecs[i].data;
            #1;
            check("fill_cpu_stall", 32'(cpu_stall), 32'(vecs[i].stall));
            @(negedge clk);
            check("fill_pending", 32'(pending), 32'(vecs[i].pend));
            if (!vecs[i].stall) begin
                t.addr = vecs[i].addr;
                t.data = vecs[i].data;
                sb.push_back(t);
                cpu_oam_we = 1'b0;
            end
        end
        ppu_vblank = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            if (k == 5) begin
                check("full_still_stalled", 32'(cpu_stall), 32'd1);
                check("full_pending_8",     32'(pending),   32'd8);
            end
            if (k == 6) begin
                check("full_stall_released", 32'(cpu_stall), 32'd0);
                check("full_pending_7",      32'(pending),   32'd7);
                t.addr = vecs[8].addr;
                t.data = vecs[8].data;
                sb.push_back(t);
            end
        end
        @(negedge clk);
        cpu_oam_we = 1'b0;
        wait_empty(60);
        tick(2);
        #1;
        check("full_write_count", 32'(n_we - base_we),     32'd9);
        check("full_done_count",  32'(n_done - base_done), 32'd1);
        ppu_vblank = 1'b0;
        tick(2);

        // vblank falls mid-drain
        base_we = n_we;
        for (int i = 0; i < 5; i++) cpu_write(8'(8'h20 + i), 8'(8'h60 + i), 1'b0);
        @(negedge clk);
        ppu_vblank = 1'b1;
        wait_we(base_we + 2, 30);
        ppu_vblank = 1'b0;
        tick(6);
        #1;
        check("abort_write_count", 32'(n_we - base_we), 32'd2);
        check("abort_pending",     32'(pending),        32'd3);
        @(negedge clk);
        ppu_vblank = 1'b1;
        wait_empty(40);
        tick(2);
        #1;
        check("resume_write_count", 32'(n_we - base_we), 32'd5);
        ppu_vblank = 1'b0;
        tick(2);

        // vblank falls during settle, next rise restarts the full settle
        base_we = n_we;
        cpu_write(8'h30, 8'h70, 1'b0);
        cpu_write(8'h31, 8'h71, 1'b0);
        @(negedge clk);
        ppu_vblank = 1'b1;
        tick(3);
        ppu_vblank = 1'b0;
        tick(10);
        #1;
        check("settle_abort_writes",  32'(n_we - base_we), 32'd0);
        check("settle_abort_pending", 32'(pending),        32'd2);
        @(negedge clk);
        ppu_vblank = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("settle_restart_timing", 32'(oam_we), 32'(k == 6));
        end
        wait_empty(20);
        tick(2);
        #1;
        check("settle_restart_writes", 32'(n_we - base_we), 32'd2);
        ppu_vblank = 1'b0;
        tick(2);

        // Duplicate address writes (coalesced only when the feature is built in)
        base_we = n_we;
        cpu_write(8'h10, 8'hAA, 1'b0);
        cpu_write(8'h10, 8'hBB, c_COAL);
        tick(1);
        check("dup_pending", 32'(pending), c_COAL ? 32'd1 : 32'd2);
        ppu_vblank = 1'b1;
        wait_empty(30);
        tick(2);
        #1;
        check("dup_write_count", 32'(n_we - base_we), c_COAL ? 32'd1 : 32'd2);
        ppu_vblank = 1'b0;
        tick(2);

        // Asynchronous reset in the middle of a drain
        base_we = n_we;
        for (int i = 0; i < 4; i++) cpu_write(8'(8'h40 + i), 8'(8'hC0 + i), 1'b0);
        @(negedge clk);
        ppu_vblank = 1'b1;
        wait_we(base_we + 1, 20);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_oam_we",  32'(oam_we),  32'd0);
        check("rst_mid_pending", 32'(pending), 32'd0);
        sb.delete();
        tick(2);
        rst = 1'b0;
        base_we = n_we;
        tick(20);
        #1;
        check("post_rst_no_writes", 32'(n_we - base_we), 32'd0);
        check("post_rst_pending",   32'(pending),        32'd0);
        check("post_rst_oam_we",    32'(oam_we),         32'd0);
        ppu_vblank = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oam_write_buffer.md
Name: oam_write_buffer

Overview:
- Responder side of the CPU sprite-instruction path. It accepts OAM byte writes from the execute/memory stage whenever the decoder asserts OAMWrite.
- Writes are queued in a small FIFO and only reach sprite OAM during PPU vblank, after a settle delay. This keeps the PPU sprite evaluation from reading OAM while it is being changed.
- It stalls the CPU when the queue is full.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- ADDR_W, 8, OAM byte address width (64 sprites x 4 bytes).
- DATA_W, 8, OAM byte width.
- SETTLE, 4, clocks to wait after the ppu_vblank rising edge before the first OAM write; range 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cpu_oam_we  in  1  write request; CPU holds it, with address and data, until accepted
- cpu_oam_addr  in  ADDR_W  OAM byte address
- cpu_oam_data  in  DATA_W  byte to write
- cpu_stall  out  1  combinational: cpu_oam_we && full; the request is not accepted this cycle
- ppu_vblank  in  1  high during vblank; synchronous to clk
- oam_we  out  1  registered OAM write strobe
- oam_addr  out  ADDR_W  registered OAM address
- oam_data  out  DATA_W  registered OAM data
- pending  out  log2(DEPTH)+1  number of occupied FIFO entries
- drain_done  out  1  one-cycle pulse when the FIFO empties during DRAIN

Behaviour:
- Reset (asynchronous, active-high):
  - wr_ptr, rd_ptr and count cleared.
  - State goes to WAIT and the settle counter is cleared.
  - oam_we=0, oam_addr=0, oam_data=0, drain_done=0, pending=0.
  - FIFO storage is not cleared.
  - Reset mid-drain discards all queued entries. An oam_we pulse in flight is cut.
- Push:
  - Happens when cpu_oam_we && !full.
  - Storage at wr_ptr is written and wr_ptr increments, wrapping modulo DEPTH.
  - When full, cpu_stall=1 and nothing is written. There is no same-cycle bypass: a pop on that cycle does not admit the push. The push is accepted on the next cycle.
- Pop:
  - Pop = (state==DRAIN) && !empty.
  - On a pop, the entry at rd_ptr is registered onto oam_addr/oam_data with oam_we=1 on the next edge, and rd_ptr increments, wrapping.
  - Latency: one entry per clock, and oam_we asserts the cycle after the pop decision.
  - When no pop occurs, oam_we=0 and oam_addr/oam_data hold their previous values.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- count and pending are count+push-pop, registered.
- vblank edge detect: ppu_vblank is registered into vb_q; rise = ppu_vblank && !vb_q.
- FSM:
  - WAIT:
    - On rise: go to SETTLE with counter=SETTLE.
    - If SETTLE==0: go directly to DRAIN.
  - SETTLE:
    - Decrement the counter each clock.
    - Go to DRAIN when the counter reaches 0 while ppu_vblank is still high.
    - If ppu_vblank drops: return to WAIT.
  - DRAIN:
    - Pop every cycle while !empty and ppu_vblank is high.
    - If the FIFO becomes empty (count reaches 0 after a pop): pulse drain_done, then stay in DRAIN. Later pushes during the same vblank drain immediately.
    - If ppu_vblank drops: go to WAIT the same cycle with no further pops. The entry already popped still produces its oam_we.
- Writes arriving outside vblank accumulate. When full, the CPU stalls until the next vblank drain.
- Ordering is strict FIFO, and duplicate addresses are written in order (unless the optional feature is compiled in).

Optional Feature:
- Macro: OAM_COALESCE_EN.
- When defined:
  - A push whose address equals the most recently pushed, still-queued entry (the tail) overwrites that entry's data in place.
  - wr_ptr and count do not change, and the write is accepted even when the FIFO is full (cpu_stall=0 for that request).
  - If the tail entry is being popped in the same cycle, coalescing is suppressed and a normal push occurs.
- When undefined: every accepted push allocates a new entry.

Test Plan:
- Reset, then 3 writes (0x00←0x11, 0x01←0x22, 0x02←0x33) with vblank low:
  - pending=3 and oam_we stays 0.
  - Raise vblank with SETTLE=4: oam_we first asserts 6 clocks after the rise (4 settle cycles, the DRAIN entry cycle, then 1 cycle output latency).
  - Three consecutive writes appear in order, and drain_done pulses once.
- Fill 8 entries with vblank low; a 9th write → cpu_stall=1 and pending stays 8. Raise vblank → after the first pop, the 9th write is accepted on the following cycle.
- Queue 5 entries and drop vblank after 2 oam_we pulses → no third pulse, pending=3. The next vblank drains the remaining 3 in order.
- Drop vblank at SETTLE count 2 → state returns to WAIT and no writes occur. The next rise restarts the full 4-cycle settle.
- With OAM_COALESCE_EN, write 0x10←0xAA then 0x10←0xBB → pending=1; drain gives a single write of 0x10←0xBB. Without the macro: pending=2, and drain writes 0xAA then 0xBB.
- Assert rst during a DRAIN of 4 entries after 1 pulse → oam_we drops immediately and pending=0. After reset there are no further writes, even with vblank high.
